// File: rtl/spi_frame_sched_pkg.sv
// rtl/spi_frame_sched_pkg.sv - shared types, constants and frame builder for spi_frame_sched
package spi_frame_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SEND  = 3'd2,
        ST_END   = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic [7:0] TYPE_FREQ  = 8'h01;
    localparam logic [7:0] TYPE_PHASE = 8'h02;
    localparam int         FRAME_LEN  = 7;

    typedef logic [FRAME_LEN-1:0][7:0] frame_t;

    // Element 0 is the first byte on the wire; payload goes out MSB first.
    function automatic frame_t build_frame(input logic [7:0] hdr, input logic [7:0] typ,
                                           input logic [31:0] pl);
        frame_t f;
        f[0] = hdr;
        f[1] = typ;
        f[2] = pl[31:24];
        f[3] = pl[23:16];
        f[4] = pl[15:8];
        f[5] = pl[7:0];
        f[6] = typ ^ pl[31:24] ^ pl[23:16] ^ pl[15:8] ^ pl[7:0];
        return f;
    endfunction

endpackage

// File: rtl/sched_rr_arb2.sv
// rtl/sched_rr_arb2.sv - two-requester round-robin arbiter, requester 0 favoured after reset
module sched_rr_arb2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req0_i,
    input  logic req1_i,
    input  logic adv_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    // last_q = 1 means requester 1 was granted last, so requester 0 has priority.
    logic last_q;

    assign gnt0_o = req0_i & (~req1_i | last_q);
    assign gnt1_o = req1_i & (~req0_i | ~last_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else if (adv_i && (gnt0_o || gnt1_o)) begin
            last_q <= gnt1_o;
        end
    end

endmodule

// File: rtl/spi_frame_sched.sv
// rtl/spi_frame_sched.sv - captures measurement results and serialises them as 7-byte SPI frames
module spi_frame_sched
    import spi_frame_sched_pkg::*;
#(
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter int unsigned GAP_CYCLES   = 100,
    parameter int unsigned DONE_TIMEOUT = 100000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        measurement_end_flag,
    input  logic [31:0] fx,
    input  logic        phase_end_flag,
    input  logic [15:0] high_times,
    input  logic [15:0] all_times,
    input  logic        send_done,
    output logic        spi_start,
    output logic        spi_end,
    output logic [7:0]  data_send,
    output logic        busy,
    output logic [15:0] frames_sent,
    output logic [7:0]  drop_cnt,
    output logic        timeout_err
);

    localparam logic [31:0] TO_LAST  = DONE_TIMEOUT - 1;
    localparam logic [31:0] GAP_LAST = (GAP_CYCLES == 0) ? 32'd0 : GAP_CYCLES - 1;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] wait_q, wait_d;
    logic [31:0] gap_q, gap_d;
    logic        abort_q, abort_d;
    logic [7:0]  data_q, data_d;
    frame_t      frame_q;
    logic        freq_pend_q, phase_pend_q;
    logic [31:0] freq_pl_q, phase_pl_q;
    logic [15:0] frames_q;
    logic [7:0]  drop_q;
    logic        tmo_err_q;
    logic        load, cnt_inc, tmo_hit;
    logic        gnt_freq, gnt_phase;
    logic        drop_freq, drop_phase;
    logic [8:0]  drop_sum;

    sched_rr_arb2 u_arb (
        .clk_i  (sys_clk),
        .rst_ni (rst_n),
        .req0_i (freq_pend_q),
        .req1_i (phase_pend_q),
        .adv_i  (state_q == ST_IDLE),
        .gnt0_o (gnt_freq),
        .gnt1_o (gnt_phase)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        gap_d   = gap_q;
        abort_d = abort_q;
        data_d  = data_q;
        load    = 1'b0;
        cnt_inc = 1'b0;
        tmo_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_freq || gnt_phase) begin
                    load    = 1'b1;
                    data_d  = HEADER;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                idx_d   = 3'd0;
                wait_d  = 32'd0;
                abort_d = 1'b0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (send_done) begin
                    wait_d = 32'd0;
                    if (idx_q == 3'(FRAME_LEN - 1)) begin
                        state_d = ST_END;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        data_d = frame_q[idx_q + 3'd1];
                    end
                end else if (wait_q >= TO_LAST) begin
                    abort_d = 1'b1;
                    tmo_hit = 1'b1;
                    state_d = ST_END;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            ST_END: begin
                cnt_inc = ~abort_q;
                gap_d   = 32'd0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q >= GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A flag landing on the grant cycle replaces data already being framed, so nothing is lost.
    assign drop_freq  = measurement_end_flag & freq_pend_q & ~(load & gnt_freq);
    assign drop_phase = phase_end_flag & phase_pend_q & ~(load & gnt_phase);
    assign drop_sum   = {1'b0, drop_q} + {8'd0, drop_freq} + {8'd0, drop_phase};

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            wait_q       <= 32'd0;
            gap_q        <= 32'd0;
            abort_q      <= 1'b0;
            data_q       <= 8'h00;
            frame_q      <= '0;
            freq_pend_q  <= 1'b0;
            phase_pend_q <= 1'b0;
            freq_pl_q    <= 32'd0;
            phase_pl_q   <= 32'd0;
            frames_q     <= 16'd0;
            drop_q       <= 8'd0;
            tmo_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            gap_q   <= gap_d;
            abort_q <= abort_d;
            data_q  <= data_d;
            if (load) begin
                frame_q <= gnt_freq ? build_frame(HEADER, TYPE_FREQ, freq_pl_q)
                                    : build_frame(HEADER, TYPE_PHASE, phase_pl_q);
            end
            if (measurement_end_flag) begin
                freq_pend_q <= 1'b1;
                freq_pl_q   <= fx;
            end else if (load && gnt_freq) begin
                freq_pend_q <= 1'b0;
            end
            if (phase_end_flag) begin
                phase_pend_q <= 1'b1;
                phase_pl_q   <= {high_times, all_times};
            end else if (load && gnt_phase) begin
                phase_pend_q <= 1'b0;
            end
            drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            if (cnt_inc) frames_q <= frames_q + 16'd1;
            if (tmo_hit) tmo_err_q <= 1'b1;
        end
    end

    assign spi_start   = (state_q == ST_START);
    assign spi_end     = (state_q == ST_END);
    assign busy        = (state_q != ST_IDLE);
    assign data_send   = data_q;
    assign frames_sent = frames_q;
    assign drop_cnt    = drop_q;
    assign timeout_err = tmo_err_q;

endmodule
